// File: rtl/ram_pkg.sv
// ram_pkg: shared types and helpers for the ram_sdp_be storage primitive.
//   ram_state_e : clear-engine states (CLEAR while zeroing memory, READY after)
//   bytes_of    : number of byte lanes in a data word
//   cfg_ok      : elaboration-time legality of a parameter set
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_e;

  function automatic int bytes_of(input int data_width);
    return data_width / 8;
  endfunction

  // DATA_WIDTH a non-zero multiple of 8, READ_LATENCY 1 or 2,
  // 2 <= MEM_DEPTH <= 2**ADDR_BUS_WIDTH.
  function automatic bit cfg_ok(input int data_width, input int addr_width,
                                input int mem_depth, input int read_latency);
    bit ok;
    ok = (data_width > 0) && ((data_width % 8) == 0);
    ok = ok && ((read_latency == 1) || (read_latency == 2));
    ok = ok && (addr_width > 0) && (addr_width < 31);
    ok = ok && (mem_depth >= 2) && (mem_depth <= (1 << addr_width));
    return ok;
  endfunction

endpackage

// File: rtl/ram_sdp_be_if.sv
// ram_sdp_be_if: request/response bundle of the simple-dual-port RAM.
//   write port : wr_en, wr_addr, wr_data, wr_be (bit i covers byte i)
//   read port  : rd_en, rd_addr -> rd_data, rd_valid
//   status     : init_busy (clear engine running), addr_err (out-of-range pulse)
// Handshake: there is no back-pressure. A request is taken on any rising edge
// where its enable is high and init_busy is low; rd_valid is a single-cycle
// pulse qualifying rd_data, and rd_data holds its value between pulses.
// master = requester, slave = RAM.
interface ram_sdp_be_if
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_BUS_WIDTH = 8
);
  localparam int BE_W = bytes_of(DATA_WIDTH);

  logic                      wr_en;
  logic [ADDR_BUS_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic [BE_W-1:0]           wr_be;
  logic                      rd_en;
  logic [ADDR_BUS_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]     rd_data;
  logic                      rd_valid;
  logic                      init_busy;
  logic                      addr_err;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    input  rd_data, rd_valid, init_busy, addr_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
    output rd_data, rd_valid, init_busy, addr_err
  );
endinterface

// File: rtl/ram_init_ctrl.sv
// ram_init_ctrl: post-reset clear engine. Walks a pointer 0..MEM_DEPTH-1,
// requesting one all-zero write per cycle, then parks in READY.
//   clk, rst     : clock, synchronous active-high reset (restarts the walk)
//   o_busy       : registered, high while in CLEAR
//   o_clr_we     : clear write strobe for the current pointer
//   o_clr_addr   : clear write address
//   o_state      : current FSM state (debug)
module ram_init_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_BUS_WIDTH = 8,
  parameter int MEM_DEPTH      = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      o_busy,
  output logic                      o_clr_we,
  output logic [ADDR_BUS_WIDTH-1:0] o_clr_addr,
  output ram_state_e                o_state
);
  localparam logic [ADDR_BUS_WIDTH-1:0] LAST_PTR = ADDR_BUS_WIDTH'(MEM_DEPTH - 1);

  ram_state_e                r_state;
  logic [ADDR_BUS_WIDTH-1:0] r_ptr;
  logic                      r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        CLEAR: begin
          // The word at r_ptr is zeroed on this same edge.
          if (r_ptr == LAST_PTR) begin
            r_state <= READY;
            r_busy  <= 1'b0;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        READY:   r_state <= READY;
        default: r_state <= CLEAR;
      endcase
    end
  end

  assign o_clr_we   = (r_state == CLEAR) && !rst;
  assign o_clr_addr = r_ptr;
  assign o_busy     = r_busy;
  assign o_state    = r_state;
endmodule

// File: rtl/ram_sdp_be.sv
// ram_sdp_be: simple-dual-port synchronous RAM with byte-enabled writes,
// READ_LATENCY 1 or 2, zero-clear after reset and out-of-range detection.
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : write port, read port, init_busy, addr_err
//   o_dbg_state  : clear-engine state (debug)
// Build option: define RAM_BYPASS_EN so a read to the address being written
// in the same cycle returns the merged word (new bytes where wr_be is set);
// without it such a read returns the old word.
module ram_sdp_be
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_BUS_WIDTH = 8,
  parameter int MEM_DEPTH      = 256,
  parameter int READ_LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst,
  ram_sdp_be_if.slave bus,
  output ram_state_e  o_dbg_state
);
  localparam int NB     = bytes_of(DATA_WIDTH);
  localparam bit CFG_OK = cfg_ok(DATA_WIDTH, ADDR_BUS_WIDTH, MEM_DEPTH, READ_LATENCY);
  // One extra bit so MEM_DEPTH == 2**ADDR_BUS_WIDTH is representable.
  localparam logic [ADDR_BUS_WIDTH:0] DEPTH = (ADDR_BUS_WIDTH + 1)'(MEM_DEPTH);

  if (!CFG_OK) begin : g_bad_cfg
    $error("ram_sdp_be: illegal DATA_WIDTH/ADDR_BUS_WIDTH/MEM_DEPTH/READ_LATENCY");
  end

  logic [DATA_WIDTH-1:0]     r_mem [MEM_DEPTH];
  logic                      w_busy, w_clr_we, w_ready;
  logic [ADDR_BUS_WIDTH-1:0] w_clr_addr;
  logic                      w_wr_acc, w_rd_acc, w_wr_inr, w_rd_inr;
  logic                      w_we;
  logic [ADDR_BUS_WIDTH-1:0] w_waddr, w_rd_ptr;
  logic [DATA_WIDTH-1:0]     w_wdata, w_rd_word;
  logic [NB-1:0]             w_wbe;
  logic                      r_s1_valid, r_err;
  logic [DATA_WIDTH-1:0]     r_s1_data;

  ram_init_ctrl #(
    .ADDR_BUS_WIDTH (ADDR_BUS_WIDTH),
    .MEM_DEPTH      (MEM_DEPTH)
  ) u_init (
    .clk        (clk),
    .rst        (rst),
    .o_busy     (w_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr),
    .o_state    (o_dbg_state)
  );

  // Requests are only taken in READY and never on a reset edge.
  assign w_ready  = !w_busy && !rst;
  assign w_wr_acc = w_ready && bus.wr_en;
  assign w_rd_acc = w_ready && bus.rd_en;
  assign w_wr_inr = ({1'b0, bus.wr_addr} < DEPTH);
  assign w_rd_inr = ({1'b0, bus.rd_addr} < DEPTH);

  // Clear engine and user writes are mutually exclusive in time.
  assign w_we    = w_clr_we || (w_wr_acc && w_wr_inr);
  assign w_waddr = w_clr_we ? w_clr_addr : bus.wr_addr;
  assign w_wdata = w_clr_we ? '0 : bus.wr_data;
  assign w_wbe   = w_clr_we ? '1 : bus.wr_be;

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < NB; b++) begin
        if (w_wbe[b]) r_mem[w_waddr][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // Keep the array index in range even when the request is out of range.
  assign w_rd_ptr = w_rd_inr ? bus.rd_addr : '0;

  always_comb begin
    w_rd_word = r_mem[w_rd_ptr];
`ifdef RAM_BYPASS_EN
    if (w_wr_acc && w_wr_inr && (bus.wr_addr == bus.rd_addr)) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.wr_be[b]) w_rd_word[8*b +: 8] = bus.wr_data[8*b +: 8];
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_s1_valid <= w_rd_acc;
      if (w_rd_acc) r_s1_data <= w_rd_inr ? w_rd_word : '0;
      // Either port out of range gives a single pulse.
      r_err <= (w_wr_acc && !w_wr_inr) || (w_rd_acc && !w_rd_inr);
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
      end else begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) r_out_data <= r_s1_data;
      end
    end

    assign bus.rd_valid = r_out_valid;
    assign bus.rd_data  = r_out_data;
  end else begin : g_lat1
    assign bus.rd_valid = r_s1_valid;
    assign bus.rd_data  = r_s1_data;
  end

  assign bus.init_busy = w_busy;
  assign bus.addr_err  = r_err;
endmodule

// File: tb/tb_ram_sdp_be.sv
// tb_ram_sdp_be: drives two RAM instances with identical directed stimulus:
//   dut_a : MEM_DEPTH=256, READ_LATENCY=1
//   dut_b : MEM_DEPTH=200, READ_LATENCY=2
// Expected read data, read timing and addr_err pulses are queued when a
// request is issued; a negedge monitor pops and compares them.
module tb_ram_sdp_be;
  import ram_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_sdp_be_if #(.DATA_WIDTH(32), .ADDR_BUS_WIDTH(8)) bus_a ();
  ram_sdp_be_if #(.DATA_WIDTH(32), .ADDR_BUS_WIDTH(8)) bus_b ();
  ram_state_e dbg_a, dbg_b;

  ram_sdp_be #(.DATA_WIDTH(32), .ADDR_BUS_WIDTH(8), .MEM_DEPTH(256), .READ_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .o_dbg_state(dbg_a)
  );
  ram_sdp_be #(.DATA_WIDTH(32), .ADDR_BUS_WIDTH(8), .MEM_DEPTH(200), .READ_LATENCY(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .o_dbg_state(dbg_b)
  );

`ifdef RAM_BYPASS_EN
  localparam logic [31:0] EXP_COLLIDE = 32'h5555AAAA;
`else
  localparam logic [31:0] EXP_COLLIDE = 32'h55555555;
`endif

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_a_q[$];
  logic [31:0] exp_b_q[$];
  int          cyc_a_q[$];
  int          cyc_b_q[$];
  int          err_b_q[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input bit we, input logic [7:0] wa, input logic [31:0] wd,
                       input logic [3:0] wbe, input bit re, input logic [7:0] ra);
    bus_a.wr_en = we; bus_a.wr_addr = wa; bus_a.wr_data = wd; bus_a.wr_be = wbe;
    bus_a.rd_en = re; bus_a.rd_addr = ra;
    bus_b.wr_en = we; bus_b.wr_addr = wa; bus_b.wr_data = wd; bus_b.wr_be = wbe;
    bus_b.rd_en = re; bus_b.rd_addr = ra;
  endtask

  // One accepted cycle: drive, queue expectations, advance to next negedge.
  task automatic step(input bit we, input logic [7:0] wa, input logic [31:0] wd,
                      input logic [3:0] wbe, input bit re, input logic [7:0] ra,
                      input logic [31:0] ea, input logic [31:0] eb);
    drive(we, wa, wd, wbe, re, ra);
    if (re) begin
      exp_a_q.push_back(ea); cyc_a_q.push_back(cyc + 1);
      exp_b_q.push_back(eb); cyc_b_q.push_back(cyc + 2);
    end
    if ((we && wa >= 8'd200) || (re && ra >= 8'd200)) err_b_q.push_back(cyc + 1);
    @(negedge clk);
    drive(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sweep_zero();
    for (int i = 0; i < 256; i++) step(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'(i), 32'd0, 32'd0);
    idle(4);
  endtask

  // Releases reset and counts busy cycles; optionally pokes requests mid-clear.
  task automatic measure_clear(input bit poke);
    int n_a = 0;
    int n_b = 0;
    rst = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (!bus_a.init_busy && !bus_b.init_busy) break;
      if (bus_a.init_busy) n_a++;
      if (bus_b.init_busy) n_b++;
      if (poke && i == 150) drive(1'b1, 8'd7, 32'hFFFFFFFF, 4'hF, 1'b1, 8'd250);
      else drive(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0);
      @(negedge clk);
    end
    drive(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0);
    chk("a_init_busy_cycles", n_a, 256);
    chk("b_init_busy_cycles", n_b, 200);
    chk("a_state_ready", dbg_a, READY);
    chk("b_state_ready", dbg_b, READY);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [31:0] d;
    int          c;
    if (bus_a.rd_valid) begin
      if (exp_a_q.size() == 0) chk("a_rd_valid_unexpected", bus_a.rd_valid, 0);
      else begin
        d = exp_a_q.pop_front(); c = cyc_a_q.pop_front();
        chk("a_rd_data", bus_a.rd_data, d);
        chk("a_rd_cycle", cyc, c);
      end
    end else if (cyc_a_q.size() > 0 && cyc_a_q[0] <= cyc) begin
      chk("a_rd_valid_missing", bus_a.rd_valid, 1);
      void'(exp_a_q.pop_front()); void'(cyc_a_q.pop_front());
    end

    if (bus_b.rd_valid) begin
      if (exp_b_q.size() == 0) chk("b_rd_valid_unexpected", bus_b.rd_valid, 0);
      else begin
        d = exp_b_q.pop_front(); c = cyc_b_q.pop_front();
        chk("b_rd_data", bus_b.rd_data, d);
        chk("b_rd_cycle", cyc, c);
      end
    end else if (cyc_b_q.size() > 0 && cyc_b_q[0] <= cyc) begin
      chk("b_rd_valid_missing", bus_b.rd_valid, 1);
      void'(exp_b_q.pop_front()); void'(cyc_b_q.pop_front());
    end

    if (bus_b.addr_err) begin
      if (err_b_q.size() > 0 && err_b_q[0] == cyc) begin
        chk("b_addr_err", bus_b.addr_err, 1);
        void'(err_b_q.pop_front());
      end else chk("b_addr_err_unexpected", bus_b.addr_err, 0);
    end else if (err_b_q.size() > 0 && err_b_q[0] <= cyc) begin
      chk("b_addr_err_missing", bus_b.addr_err, 1);
      void'(err_b_q.pop_front());
    end

    if (bus_a.addr_err) chk("a_addr_err_unexpected", bus_a.addr_err, 0);
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    drive(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0);
    rst = 1'b1;
    idle(3);
    chk("a_rst_rd_data", bus_a.rd_data, 0);
    chk("b_rst_rd_data", bus_b.rd_data, 0);
    chk("a_rst_rd_valid", bus_a.rd_valid, 0);
    chk("b_rst_rd_valid", bus_b.rd_valid, 0);
    chk("a_rst_addr_err", bus_a.addr_err, 0);
    chk("a_rst_init_busy", bus_a.init_busy, 1);
    chk("b_rst_init_busy", bus_b.init_busy, 1);
    chk("a_rst_state", dbg_a, CLEAR);

    measure_clear(1'b0);
    sweep_zero();

    // Byte-enable merge and read-data hold.
    step(1'b1, 8'd5, 32'hDEADBEEF, 4'b1111, 1'b0, 8'd0, 32'd0, 32'd0);
    step(1'b1, 8'd5, 32'h00001200, 4'b0010, 1'b0, 8'd0, 32'd0, 32'd0);
    step(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd5, 32'hDEAD12EF, 32'hDEAD12EF);
    idle(3);
    chk("a_rd_data_hold", bus_a.rd_data, 32'hDEAD12EF);
    chk("b_rd_data_hold", bus_b.rd_data, 32'hDEAD12EF);

    // Same-cycle collision, then write visible on the following read.
    step(1'b1, 8'd9, 32'h55555555, 4'b1111, 1'b0, 8'd0, 32'd0, 32'd0);
    step(1'b1, 8'd9, 32'hAAAAAAAA, 4'b0011, 1'b1, 8'd9, EXP_COLLIDE, EXP_COLLIDE);
    step(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd9, 32'h5555AAAA, 32'h5555AAAA);
    // All-zero byte enable is a no-op, even on a colliding read.
    step(1'b1, 8'd9, 32'hFFFFFFFF, 4'b0000, 1'b1, 8'd9, 32'h5555AAAA, 32'h5555AAAA);
    step(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd9, 32'h5555AAAA, 32'h5555AAAA);
    // Concurrent write and read to different addresses.
    step(1'b1, 8'd6, 32'h600DF00D, 4'b1111, 1'b1, 8'd5, 32'hDEAD12EF, 32'hDEAD12EF);
    step(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd6, 32'h600DF00D, 32'h600DF00D);

    // Range boundaries: 210/220/230/250 are out of range for dut_b only.
    step(1'b1, 8'd210, 32'h11111111, 4'b1111, 1'b0, 8'd0, 32'd0, 32'd0);
    step(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd210, 32'h11111111, 32'h00000000);
    step(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd250, 32'h00000000, 32'h00000000);
    step(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd10, 32'h00000000, 32'h00000000);
    step(1'b1, 8'd220, 32'h22222222, 4'b1111, 1'b1, 8'd230, 32'h00000000, 32'h00000000);
    step(1'b1, 8'd199, 32'hC0FFEE99, 4'b1111, 1'b1, 8'd200, 32'h00000000, 32'h00000000);
    step(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd199, 32'hC0FFEE99, 32'hC0FFEE99);
    step(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd220, 32'h22222222, 32'h00000000);
    idle(2);

    // Back-to-back reads at full throughput.
    step(1'b1, 8'd1, 32'h01010101, 4'b1111, 1'b0, 8'd0, 32'd0, 32'd0);
    step(1'b1, 8'd2, 32'h02020202, 4'b1111, 1'b0, 8'd0, 32'd0, 32'd0);
    step(1'b1, 8'd3, 32'h03030303, 4'b1111, 1'b0, 8'd0, 32'd0, 32'd0);
    step(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd1, 32'h01010101, 32'h01010101);
    step(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd2, 32'h02020202, 32'h02020202);
    step(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd3, 32'h03030303, 32'h03030303);
    idle(4);

    // Reset with reads in flight: dut_a returns the first read before the
    // reset edge; dut_b's copy is still in its pipeline and must vanish.
    drive(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd5);
    exp_a_q.push_back(32'hDEAD12EF); cyc_a_q.push_back(cyc + 1);
    @(negedge clk);
    drive(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd6);
    rst = 1'b1;
    @(negedge clk);
    drive(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0);
    idle(3);
    chk("a_flush_rd_data", bus_a.rd_data, 0);
    chk("b_flush_rd_data", bus_b.rd_data, 0);

    // Reset again mid-clear with the pointer at 100; clear restarts from 0.
    rst = 1'b0;
    idle(100);
    chk("a_midclear_busy", bus_a.init_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    measure_clear(1'b1);
    sweep_zero();

    idle(4);
    chk("a_exp_queue_drained", exp_a_q.size(), 0);
    chk("b_exp_queue_drained", exp_b_q.size(), 0);
    chk("b_err_queue_drained", err_b_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
